// File: rtl/up_down_mod_counter.sv
// Synchronous modulo-MODULUS up/down counter with parallel load and range clamping.
// Terminal count is combinational; wrap and load-error flags are registered one-cycle pulses.
module up_down_mod_counter #(
    parameter int unsigned     WIDTH   = 3,
    parameter longint unsigned MODULUS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "up_down_mod_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "up_down_mod_counter: MODULUS must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == MAX_VAL);
    assign at_zero = (count_q == '0);

    // Explicit compares are used even at full range, where they agree with natural overflow.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_val > MAX_VAL) begin
                count_d    = MAX_VAL;
                load_err_d = 1'b1;
            end else begin
                count_d = load_val;
            end
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign q        = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign tc       = en & ~load & (up ? at_max : at_zero);

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Bench for up_down_mod_counter: a WIDTH=3/MODULUS=6 instance driven from a vector table
// and hand sequences, plus a WIDTH=4/MODULUS=16 full-range instance; both run against a model.
module tb_up_down_mod_counter;

    typedef struct {
        bit         rst;
        logic       en;
        logic       up;
        logic       load;
        logic [2:0] lv;
        logic       expTc;
        logic [2:0] expQ;
        logic       expWrap;
        logic       expErr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en6 = 1'b0, up6 = 1'b0, load6 = 1'b0;
    logic [2:0] lv6 = '0, q6;
    logic       tc6, wrap6, err6;
    logic       en16 = 1'b0, up16 = 1'b0, load16 = 1'b0;
    logic [3:0] lv16 = '0, q16;
    logic       tc16, wrap16, err16;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    up_down_mod_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
        .clk(clk), .reset(reset), .en(en6), .up(up6), .load(load6), .load_val(lv6),
        .q(q6), .tc(tc6), .wrap(wrap6), .load_err(err6)
    );

    up_down_mod_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .reset(reset), .en(en16), .up(up16), .load(load16), .load_val(lv16),
        .q(q16), .tc(tc16), .wrap(wrap16), .load_err(err16)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    function automatic vec_t v(bit rst, logic e, logic u, logic l, logic [2:0] val,
                               logic t, logic [2:0] eq, logic w, logic er);
        vec_t r;
        r.rst = rst; r.en = e; r.up = u; r.load = l; r.lv = val;
        r.expTc = t; r.expQ = eq; r.expWrap = w; r.expErr = er;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        en6 = 0; load6 = 0; en16 = 0; load16 = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Inputs change on the falling edge; tc is checked before the rising edge, registers after it.
    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        en6 = t.en; up6 = t.up; load6 = t.load; lv6 = t.lv;
        #1;
        checkOutput("tc6", int'(tc6), int'(t.expTc));
        @(posedge clk);
        #1;
        checkOutput("q6", int'(q6), int'(t.expQ));
        checkOutput("wrap6", int'(wrap6), int'(t.expWrap));
        checkOutput("load_err6", int'(err6), int'(t.expErr));
    endtask

    task automatic step16(input logic e, input logic u, input logic l, input logic [3:0] val,
                          input int expTc, input int expQ, input int expWrap, input int expErr);
        @(negedge clk);
        en16 = e; up16 = u; load16 = l; lv16 = val;
        #1;
        checkOutput("tc16", int'(tc16), expTc);
        @(posedge clk);
        #1;
        checkOutput("q16", int'(q16), expQ);
        checkOutput("wrap16", int'(wrap16), expWrap);
        checkOutput("load_err16", int'(err16), expErr);
    endtask

    // Reference step: integer arithmetic modulo the configured range.
    task automatic modelStep(input int m, input int cur, input bit e, input bit u, input bit l,
                             input int val, output int nq, output int nw, output int ne);
        nq = cur; nw = 0; ne = 0;
        if (l) begin
            if (val >= m) begin nq = m - 1; ne = 1; end
            else nq = val;
        end else if (e) begin
            if (u) begin nq = (cur + 1) % m; nw = (cur == m - 1) ? 1 : 0; end
            else begin nq = (cur + m - 1) % m; nw = (cur == 0) ? 1 : 0; end
        end
    endtask

    initial begin
        int mq6, mq16, nq, nw, ne, expTc;
        bit e, u, l;
        int val6, val16;

        // Up-count wrap from reset
        vecs.push_back(v(1, 1, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 2, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 4, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 5, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 1, 0, 1, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 2, 0, 0));
        // Down-count wrap from reset
        vecs.push_back(v(1, 1, 0, 0, 0, 1, 5, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 4, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 1, 5, 1, 0));
        // Loads: in range, clamped, load beats count at terminal value, boundary value
        vecs.push_back(v(0, 0, 0, 1, 4, 0, 4, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 7, 0, 5, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 5, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 2, 0, 2, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 6, 0, 5, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 7, 0, 5, 0, 1));
        vecs.push_back(v(0, 1, 1, 1, 5, 0, 5, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 0, 0, 0, 0, 0));
        // Hold at 3, then direction toggle every cycle
        vecs.push_back(v(0, 0, 0, 1, 3, 0, 3, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 4, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 4, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 3, 0, 0));

        $display("[TB] starting");
        reset = 1'b1;
        #2;
        checkOutput("reset_q6", int'(q6), 0);
        checkOutput("reset_wrap6", int'(wrap6), 0);
        checkOutput("reset_err6", int'(err6), 0);
        doReset();

        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i]);
        end

        // Asynchronous reset with a wrap pulse pending, held across a counting edge
        applyStimulus(v(0, 0, 0, 1, 0, 0, 0, 0, 0));
        applyStimulus(v(0, 1, 0, 0, 0, 1, 5, 1, 0));
        #2 reset = 1'b1;
        #1;
        checkOutput("async_q6", int'(q6), 0);
        checkOutput("async_wrap6", int'(wrap6), 0);
        @(posedge clk);
        #1;
        checkOutput("held_q6", int'(q6), 0);
        @(negedge clk);
        reset = 1'b0; en6 = 1; up6 = 1; load6 = 0;
        @(posedge clk);
        #1;
        checkOutput("release_q6", int'(q6), 1);
        checkOutput("release_wrap6", int'(wrap6), 0);

        // Asynchronous reset kills a pending load_err pulse
        applyStimulus(v(0, 0, 0, 1, 7, 0, 5, 0, 1));
        #2 reset = 1'b1;
        #1;
        checkOutput("async_err6", int'(err6), 0);
        checkOutput("async_q6b", int'(q6), 0);
        @(negedge clk);
        reset = 1'b0; en6 = 0; load6 = 0;

        // Full-range instance: natural overflow and underflow
        step16(0, 1, 1, 4'd15, 0, 15, 0, 0);
        step16(1, 1, 0, 4'd0, 1, 0, 1, 0);
        step16(1, 0, 0, 4'd0, 1, 15, 1, 0);
        step16(1, 0, 0, 4'd0, 0, 14, 0, 0);
        step16(0, 0, 0, 4'd0, 0, 14, 0, 0);

        // Randomised traffic on both instances against the model
        doReset();
        mq6 = 0; mq16 = 0;
        for (int n = 0; n < 256; n++) begin
            @(negedge clk);
            e = 1'($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            l = 1'($urandom_range(0, 7) == 0);
            val6 = $urandom_range(0, 7);
            val16 = $urandom_range(0, 15);
            en6 = e; up6 = u; load6 = l; lv6 = 3'(val6);
            en16 = e; up16 = u; load16 = l; lv16 = 4'(val16);
            #1;
            expTc = (e && !l && (u ? (mq6 == 5) : (mq6 == 0))) ? 1 : 0;
            checkOutput("rand_tc6", int'(tc6), expTc);
            expTc = (e && !l && (u ? (mq16 == 15) : (mq16 == 0))) ? 1 : 0;
            checkOutput("rand_tc16", int'(tc16), expTc);
            @(posedge clk);
            #1;
            modelStep(6, mq6, e, u, l, val6, nq, nw, ne);
            mq6 = nq;
            checkOutput("rand_q6", int'(q6), nq);
            checkOutput("rand_wrap6", int'(wrap6), nw);
            checkOutput("rand_err6", int'(err6), ne);
            checkOutput("rand_q6_in_range", (int'(q6) < 6) ? 1 : 0, 1);
            modelStep(16, mq16, e, u, l, val16, nq, nw, ne);
            mq16 = nq;
            checkOutput("rand_q16", int'(q16), nq);
            checkOutput("rand_wrap16", int'(wrap16), nw);
            checkOutput("rand_err16", int'(err16), ne);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
